bpi_cmd_sequencer: RTL and testbench

- Upstream command sequencer for the BPI flash interface.
- Turns one high-level request (read word, program word, erase block, read status) into the multi-cycle command sequence the parallel NOR flash needs: unlock, setup/confirm, status poll, clear status and return to read-array.
- Drives the single-transaction ADDR/CMD_DATA_OUT/OP/EXECUTE port of the BPI interface and consumes its BUSY/LOAD_DATA/DATA_IN.

---
 rtl/bpi_cmd_sequencer_pkg.sv | 130 +++++++++++++
 rtl/bpi_xact_handshake.sv | 73 +++++++
 rtl/bpi_cmd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_bpi_cmd_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpi_cmd_sequencer_pkg.sv
// Shared encodings and the per-opcode step ROM
// for the BPI flash command sequencer.
package bpi_cmd_sequencer_pkg;

  localparam logic [1:0] OPC_READ   = 2'b00;
  localparam logic [1:0] OPC_PROG   = 2'b01;
  localparam logic [1:0] OPC_ERASE  = 2'b10;
  localparam logic [1:0] OPC_STATUS = 2'b11;

  localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;
  localparam logic [15:0] CMD_RD_STATUS  = 16'h0070;
  localparam logic [15:0] CMD_CLR_STATUS = 16'h0050;
  localparam logic [15:0] CMD_UNLK_SETUP = 16'h0060;
  localparam logic [15:0] CMD_CONFIRM    = 16'h00D0;
  localparam logic [15:0] CMD_PROG_SETUP = 16'h0040;
  localparam logic [15:0] CMD_ERAS_SETUP = 16'h0020;

  localparam int SR_READY = 7;
  localparam int SR_ERASE = 5;
  localparam int SR_PROG  = 4;
  localparam int SR_VPP   = 3;
  localparam int SR_LOCK  = 1;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [3:0] POLL_IDX = 4'd4;

  typedef enum logic [1:0] {
    K_WR,
    K_RD,
    K_POLL,
    K_END
  } step_kind_e;

  typedef struct packed {
    step_kind_e  kind;
    logic        blk;
    logic        use_data;
    logic [15:0] cmd;
  } step_t;

  function automatic step_t wr(input logic b, input logic [15:0] c);
    step_t s;
    s.kind     = K_WR;
    s.blk      = b;
    s.use_data = 1'b0;
    s.cmd      = c;
    return s;
  endfunction

  function automatic step_t wr_data();
    step_t s;
    s.kind     = K_WR;
    s.blk      = 1'b0;
    s.use_data = 1'b1;
    s.cmd      = 16'h0000;
    return s;
  endfunction

  function automatic step_t mk(input step_kind_e k);
    step_t s;
    s.kind     = k;
    s.blk      = 1'b0;
    s.use_data = 1'b0;
    s.cmd      = 16'h0000;
    return s;
  endfunction

  function automatic step_t step_rom(
    input logic [1:0] opc,
    input logic [3:0] idx
  );
    step_t s;
    s = mk(K_END);
    case (opc)
      OPC_READ: begin
        case (idx)
          4'd0:    s = wr(1'b0, CMD_READ_ARRAY);
          4'd1:    s = mk(K_RD);
          default: s = mk(K_END);
        endcase
      end
      OPC_PROG: begin
        case (idx)
          4'd0:     s = wr(1'b1, CMD_UNLK_SETUP);
          4'd1:     s = wr(1'b1, CMD_CONFIRM);
          4'd2:     s = wr(1'b0, CMD_PROG_SETUP);
          4'd3:     s = wr_data();
          POLL_IDX: s = mk(K_POLL);
          4'd5:     s = wr(1'b0, CMD_CLR_STATUS);
          4'd6:     s = wr(1'b0, CMD_READ_ARRAY);
          default:  s = mk(K_END);
        endcase
      end
      OPC_ERASE: begin
        case (idx)
          4'd0:     s = wr(1'b1, CMD_UNLK_SETUP);
          4'd1:     s = wr(1'b1, CMD_CONFIRM);
          4'd2:     s = wr(1'b1, CMD_ERAS_SETUP);
          4'd3:     s = wr(1'b1, CMD_CONFIRM);
          POLL_IDX: s = mk(K_POLL);
          4'd5:     s = wr(1'b1, CMD_CLR_STATUS);
          4'd6:     s = wr(1'b1, CMD_READ_ARRAY);
          default:  s = mk(K_END);
        endcase
      end
      default: begin
        case (idx)
          4'd0:    s = wr(1'b0, CMD_RD_STATUS);
          4'd1:    s = mk(K_RD);
          4'd2:    s = wr(1'b0, CMD_READ_ARRAY);
          default: s = mk(K_END);
        endcase
      end
    endcase
    return s;
  endfunction

  function automatic logic step_is_end(
    input logic [1:0] opc,
    input logic [3:0] idx
  );
    step_t s;
    s = step_rom(opc, idx);
    return s.kind == K_END;
  endfunction

endpackage

// File: rtl/bpi_xact_handshake.sv
// One BPI bus transaction: issue strobe, wait for
// BUSY to rise then fall, capture read data.
module bpi_xact_handshake
  import bpi_cmd_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [22:0] go_addr,
  input  logic [15:0] go_data,
  input  logic [1:0]  go_op,
  input  logic        busy,
  input  logic        load_data,
  input  logic [15:0] data_in,
  output logic [22:0] addr,
  output logic [15:0] cmd_data_out,
  output logic [1:0]  op,
  output logic        execute,
  output logic        xact_done,
  output logic [15:0] rdata
);

  localparam logic [1:0] H_IDLE    = 2'd0;
  localparam logic [1:0] H_ISSUE   = 2'd1;
  localparam logic [1:0] H_WAIT_HI = 2'd2;
  localparam logic [1:0] H_WAIT_LO = 2'd3;

  logic [1:0]  st;
  logic [15:0] rdata_q;
  logic        cap;

  assign cap = load_data && (op == OP_READ) && (st != H_IDLE);
  assign xact_done = (st == H_WAIT_LO) && !busy;
  // forward data that lands in the completing cycle
  assign rdata = cap ? data_in : rdata_q;

  // Transaction engine; bus outputs held until BUSY falls
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= H_IDLE;
      addr         <= '0;
      cmd_data_out <= '0;
      op           <= OP_IDLE;
      execute      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      execute <= 1'b0;
      case (st)
        H_IDLE: begin
          if (go) begin
            addr         <= go_addr;
            cmd_data_out <= go_data;
            op           <= go_op;
            execute      <= 1'b1;
            st           <= H_ISSUE;
          end
        end
        H_ISSUE: st <= H_WAIT_HI;
        H_WAIT_HI: begin
          if (busy) st <= H_WAIT_LO;
        end
        default: begin
          if (!busy) begin
            st <= H_IDLE;
            op <= OP_IDLE;
          end
        end
      endcase
      if (cap) rdata_q <= data_in;
    end
  end

endmodule

// File: rtl/bpi_cmd_sequencer.sv
// Expands one flash request into the BPI command
// sequence: unlock, setup/confirm, poll, clear.
module bpi_cmd_sequencer
  import bpi_cmd_sequencer_pkg::*;
#(
  parameter logic [23:0] POLL_MAX = 24'd4_000_000,
  parameter logic [22:0] BLK_MASK = 23'h7F_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  OPCODE,
  input  logic [22:0] REQ_ADDR,
  input  logic [15:0] REQ_DATA,
  output logic        READY,
  output logic        DONE,
  output logic        ERR,
  output logic        TIMEOUT,
  output logic [15:0] RD_DATA,
  output logic [22:0] ADDR,
  output logic [15:0] CMD_DATA_OUT,
  output logic [1:0]  OP,
  output logic        EXECUTE,
  input  logic        BUSY,
  input  logic        LOAD_DATA,
  input  logic [15:0] DATA_IN
);

  localparam int CW = $clog2(int'(POLL_MAX) + 1);
  localparam logic [CW-1:0] PMAX = POLL_MAX[CW-1:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_XACT = 2'd2;

  logic [1:0]    state;
  logic [1:0]    opc_q;
  logic [22:0]   addr_q;
  logic [15:0]   data_q;
  logic [3:0]    idx;
  logic          poll_ph;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          done_q;
  logic          err_q;
  logic          to_q;
  logic [15:0]   rd_q;

  step_t         cur;
  logic          nxt_end;
  logic          go;
  logic [22:0]   go_addr;
  logic [15:0]   go_data;
  logic [1:0]    go_op;
  logic          xact_done;
  logic [15:0]   rdata;
  logic          sr_ok;
  logic          sr_err;
  logic          poll_lim;
  logic          adv;

  assign cur     = step_rom(opc_q, idx);
  assign nxt_end = step_is_end(opc_q, idx + 4'd1);
  assign cnt_n   = cnt + CW'(1);
  assign sr_ok   = rdata[SR_READY];
  assign sr_err  = rdata[SR_ERASE] | rdata[SR_PROG]
                 | rdata[SR_VPP] | rdata[SR_LOCK];
  assign poll_lim = (cnt_n == PMAX);
  assign go      = (state == S_STEP);

  assign READY   = (state == S_IDLE);
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign TIMEOUT = to_q;
  assign RD_DATA = rd_q;

  // Step completes unless the poll loop must read again
  always_comb begin
    adv = 1'b0;
    if (xact_done) begin
      if (cur.kind != K_POLL) adv = 1'b1;
      else adv = poll_ph && (sr_ok || poll_lim);
    end
  end

  // Bus fields for the current step (poll: 0070 then reads)
  always_comb begin
    go_addr = cur.blk ? (addr_q & BLK_MASK) : addr_q;
    go_data = cur.use_data ? data_q : cur.cmd;
    go_op   = (cur.kind == K_RD) ? OP_READ : OP_WRITE;
    if (cur.kind == K_POLL) begin
      go_addr = addr_q;
      go_data = CMD_RD_STATUS;
      go_op   = poll_ph ? OP_READ : OP_WRITE;
    end
  end

  bpi_xact_handshake u_xact (
    .clk          (CLK),
    .rst          (RST),
    .go           (go),
    .go_addr      (go_addr),
    .go_data      (go_data),
    .go_op        (go_op),
    .busy         (BUSY),
    .load_data    (LOAD_DATA),
    .data_in      (DATA_IN),
    .addr         (ADDR),
    .cmd_data_out (CMD_DATA_OUT),
    .op           (OP),
    .execute      (EXECUTE),
    .xact_done    (xact_done),
    .rdata        (rdata)
  );

  // Request capture, step walk and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      opc_q   <= OPC_READ;
      addr_q  <= '0;
      data_q  <= '0;
      idx     <= '0;
      poll_ph <= 1'b0;
      cnt     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            opc_q   <= OPCODE;
            addr_q  <= REQ_ADDR;
            data_q  <= REQ_DATA;
            idx     <= '0;
            poll_ph <= 1'b0;
            cnt     <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            state   <= S_STEP;
          end
        end
        S_STEP: state <= S_XACT;
        S_XACT: begin
          if (xact_done) begin
            if (cur.kind == K_RD) rd_q <= rdata;
            if (cur.kind == K_POLL) begin
              if (!poll_ph) begin
                poll_ph <= 1'b1;
              end else begin
                cnt <= cnt_n;
                if (sr_ok) begin
                  rd_q  <= rdata;
                  err_q <= sr_err;
                end else if (poll_lim) begin
                  rd_q  <= rdata;
                  err_q <= 1'b1;
                  to_q  <= 1'b1;
                end
              end
            end
            if (adv) begin
              idx     <= idx + 4'd1;
              poll_ph <= 1'b0;
            end
            if (adv && nxt_end) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else begin
              state <= S_STEP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpi_cmd_sequencer.sv
// Directed bench for bpi_cmd_sequencer with a
// behavioural BPI/flash responder.
module tb_bpi_cmd_sequencer;

  logic        clk;
  logic        RST;
  logic        START;
  logic [1:0]  OPCODE;
  logic [22:0] REQ_ADDR;
  logic [15:0] REQ_DATA;
  logic        READY;
  logic        DONE;
  logic        ERR;
  logic        TIMEOUT;
  logic [15:0] RD_DATA;
  logic [22:0] ADDR;
  logic [15:0] CMD_DATA_OUT;
  logic [1:0]  OP;
  logic        EXECUTE;
  logic        BUSY;
  logic        LOAD_DATA;
  logic [15:0] DATA_IN;

  bpi_cmd_sequencer #(
    .POLL_MAX (24'd8),
    .BLK_MASK (23'h7F_0000)
  ) dut (
    .CLK          (clk),
    .RST          (RST),
    .START        (START),
    .OPCODE       (OPCODE),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_DATA     (REQ_DATA),
    .READY        (READY),
    .DONE         (DONE),
    .ERR          (ERR),
    .TIMEOUT      (TIMEOUT),
    .RD_DATA      (RD_DATA),
    .ADDR         (ADDR),
    .CMD_DATA_OUT (CMD_DATA_OUT),
    .OP           (OP),
    .EXECUTE      (EXECUTE),
    .BUSY         (BUSY),
    .LOAD_DATA    (LOAD_DATA),
    .DATA_IN      (DATA_IN)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // ---------------- flash / BPI responder ----------------
  logic [22:0] xa[$];
  logic [15:0] xd[$];
  logic [1:0]  xo[$];
  logic [15:0] srq[$];
  int          busy_len   = 2;
  int          pre_dly    = 1;
  int          stab_bad   = 0;
  int          sreads     = 0;
  int          fall_cyc   = 0;
  bit          skip_chk   = 0;
  bit          model_idle = 1;
  bit          stat_mode  = 0;
  logic [22:0] ma;
  logic [15:0] md;
  logic [15:0] mv;
  logic [1:0]  mo;

  task automatic stab_chk();
    if (!skip_chk && (ADDR !== ma || CMD_DATA_OUT !== md ||
                      OP !== mo || EXECUTE !== 1'b0))
      stab_bad++;
  endtask

  initial begin
    BUSY = 0;
    LOAD_DATA = 0;
    DATA_IN = 0;
    forever begin
      @(negedge clk);
      if (EXECUTE === 1'b1) begin
        model_idle = 0;
        ma = ADDR;
        md = CMD_DATA_OUT;
        mo = OP;
        xa.push_back(ma);
        xd.push_back(md);
        xo.push_back(mo);
        mv = 16'h0000;
        if (mo == 2'b10) begin
          if (stat_mode) begin
            sreads++;
            if (srq.size() > 0) mv = srq.pop_front();
          end else begin
            mv = 16'hBEEF;
          end
        end else if (md == 16'h0070) begin
          stat_mode = 1;
        end else if (md == 16'h00FF) begin
          stat_mode = 0;
        end
        for (int k = 0; k < pre_dly; k++) begin
          @(negedge clk);
          stab_chk();
        end
        BUSY = 1;
        for (int k = 1; k < busy_len; k++) begin
          @(negedge clk);
          stab_chk();
        end
        if (mo == 2'b10) begin
          LOAD_DATA = 1;
          DATA_IN = mv;
        end
        @(negedge clk);
        stab_chk();
        BUSY = 0;
        LOAD_DATA = 0;
        fall_cyc = cyc;
        model_idle = 1;
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic do_req(input logic [1:0] opc, input logic [22:0] a,
                        input logic [15:0] d, output bit seen,
                        output int ndone, output int gap,
                        output logic rdy);
    @(negedge clk);
    OPCODE = opc;
    REQ_ADDR = a;
    REQ_DATA = d;
    START = 1;
    @(negedge clk);
    START = 0;
    seen = 0;
    ndone = 0;
    gap = -1;
    rdy = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (DONE) begin
        seen = 1;
        ndone = 1;
        gap = cyc - fall_cyc;
        rdy = READY;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (DONE) ndone++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]        opc;
    logic [22:0]       addr;
    logic [15:0]       data;
    int                nsr;
    logic [2:0][15:0]  sr;
    int                n;
    logic [15:0][22:0] ea;
    logic [15:0][15:0] ed;
    logic [15:0][1:0]  eo;
    int                sreads;
    logic [15:0]       rd;
    logic              err;
    logic              to;
  } vec_t;

  localparam int NV = 5;
  vec_t vt[NV];

  task automatic newv(input int v, input logic [1:0] opc,
                      input logic [22:0] a, input logic [15:0] d,
                      input logic [15:0] rd, input logic err,
                      input logic to, input int sr_n);
    vt[v].opc = opc;
    vt[v].addr = a;
    vt[v].data = d;
    vt[v].nsr = 0;
    vt[v].sr = '0;
    vt[v].n = 0;
    vt[v].ea = '0;
    vt[v].ed = '0;
    vt[v].eo = '0;
    vt[v].sreads = sr_n;
    vt[v].rd = rd;
    vt[v].err = err;
    vt[v].to = to;
  endtask

  task automatic addsr(input int v, input logic [15:0] s);
    vt[v].sr[vt[v].nsr] = s;
    vt[v].nsr++;
  endtask

  task automatic addx(input int v, input logic [1:0] o,
                      input logic [22:0] a, input logic [15:0] d);
    vt[v].ea[vt[v].n] = a;
    vt[v].ed[vt[v].n] = d;
    vt[v].eo[vt[v].n] = o;
    vt[v].n++;
  endtask

  localparam logic [1:0] W = 2'b01;
  localparam logic [1:0] R = 2'b10;

  bit          seen;
  int          ndone;
  int          gap;
  logic        rdy;
  int          nx;
  int          nex;

  initial begin
    RST = 1;
    START = 0;
    OPCODE = 0;
    REQ_ADDR = 0;
    REQ_DATA = 0;
    repeat (3) @(negedge clk);
    chk("rst READY", READY, 1);
    chk("rst DONE", DONE, 0);
    chk("rst ERR", ERR, 0);
    chk("rst TIMEOUT", TIMEOUT, 0);
    chk("rst RD_DATA", RD_DATA, 0);
    chk("rst ADDR", ADDR, 0);
    chk("rst CMD", CMD_DATA_OUT, 0);
    chk("rst OP", OP, 0);
    chk("rst EXECUTE", EXECUTE, 0);
    RST = 0;
    @(negedge clk);

    // read word
    newv(0, 2'b00, 23'h012345, 16'h0000, 16'hBEEF, 0, 0, 0);
    addx(0, W, 23'h012345, 16'h00FF);
    addx(0, R, 23'h012345, 16'h0000);
    // program word, SR 00,00,80
    newv(1, 2'b01, 23'h020010, 16'h1234, 16'h0080, 0, 0, 3);
    addsr(1, 16'h0000);
    addsr(1, 16'h0000);
    addsr(1, 16'h0080);
    addx(1, W, 23'h020000, 16'h0060);
    addx(1, W, 23'h020000, 16'h00D0);
    addx(1, W, 23'h020010, 16'h0040);
    addx(1, W, 23'h020010, 16'h1234);
    addx(1, W, 23'h020010, 16'h0070);
    addx(1, R, 23'h020010, 16'h0000);
    addx(1, R, 23'h020010, 16'h0000);
    addx(1, R, 23'h020010, 16'h0000);
    addx(1, W, 23'h020010, 16'h0050);
    addx(1, W, 23'h020010, 16'h00FF);
    // erase block, SR A0 -> erase error
    newv(2, 2'b10, 23'h03ABCD, 16'h0000, 16'h00A0, 1, 0, 1);
    addsr(2, 16'h00A0);
    addx(2, W, 23'h030000, 16'h0060);
    addx(2, W, 23'h030000, 16'h00D0);
    addx(2, W, 23'h030000, 16'h0020);
    addx(2, W, 23'h030000, 16'h00D0);
    addx(2, W, 23'h03ABCD, 16'h0070);
    addx(2, R, 23'h03ABCD, 16'h0000);
    addx(2, W, 23'h030000, 16'h0050);
    addx(2, W, 23'h030000, 16'h00FF);
    // read status
    newv(3, 2'b11, 23'h000100, 16'h0000, 16'h0082, 0, 0, 1);
    addsr(3, 16'h0082);
    addx(3, W, 23'h000100, 16'h0070);
    addx(3, R, 23'h000100, 16'h0000);
    addx(3, W, 23'h000100, 16'h00FF);
    // program with SR stuck at 00 -> timeout after 8 reads
    newv(4, 2'b01, 23'h000004, 16'h5555, 16'h0000, 1, 1, 8);
    addx(4, W, 23'h000000, 16'h0060);
    addx(4, W, 23'h000000, 16'h00D0);
    addx(4, W, 23'h000004, 16'h0040);
    addx(4, W, 23'h000004, 16'h5555);
    addx(4, W, 23'h000004, 16'h0070);
    for (int i = 0; i < 8; i++) addx(4, R, 23'h000004, 16'h0000);
    addx(4, W, 23'h000004, 16'h0050);
    addx(4, W, 23'h000004, 16'h00FF);

    for (int v = 0; v < NV; v++) begin
      xa.delete();
      xd.delete();
      xo.delete();
      srq.delete();
      sreads = 0;
      for (int s = 0; s < vt[v].nsr; s++) srq.push_back(vt[v].sr[s]);
      do_req(vt[v].opc, vt[v].addr, vt[v].data, seen, ndone, gap, rdy);
      chk($sformatf("v%0d done seen", v), seen, 1);
      chk($sformatf("v%0d done pulses", v), ndone, 1);
      chk($sformatf("v%0d done gap", v), gap, 1);
      chk($sformatf("v%0d ready at done", v), rdy, 1);
      chk($sformatf("v%0d xact count", v), xa.size(), vt[v].n);
      chk($sformatf("v%0d status reads", v), sreads, vt[v].sreads);
      for (int i = 0; i < vt[v].n; i++) begin
        if (i < xa.size()) begin
          chk($sformatf("v%0d x%0d op", v, i), xo[i], vt[v].eo[i]);
          chk($sformatf("v%0d x%0d addr", v, i), xa[i], vt[v].ea[i]);
          if (vt[v].eo[i] == W)
            chk($sformatf("v%0d x%0d data", v, i), xd[i], vt[v].ed[i]);
        end
      end
      chk($sformatf("v%0d RD_DATA", v), RD_DATA, vt[v].rd);
      chk($sformatf("v%0d ERR", v), ERR, vt[v].err);
      chk($sformatf("v%0d TIMEOUT", v), TIMEOUT, vt[v].to);
    end
    chk("bus stable", stab_bad, 0);

    // second START while busy is dropped
    xa.delete();
    xd.delete();
    xo.delete();
    @(negedge clk);
    OPCODE = 2'b00;
    REQ_ADDR = 23'h000777;
    START = 1;
    @(negedge clk);
    START = 0;
    repeat (3) @(negedge clk);
    chk("busy READY", READY, 0);
    OPCODE = 2'b10;
    REQ_ADDR = 23'h050000;
    START = 1;
    @(negedge clk);
    START = 0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (DONE) ndone++;
    end
    chk("drop start xacts", xa.size(), 2);
    chk("drop start done", ndone, 1);
    chk("drop start RD_DATA", RD_DATA, 16'hBEEF);

    // RST mid-erase while waiting for BUSY to rise
    xa.delete();
    xd.delete();
    xo.delete();
    skip_chk = 1;
    pre_dly = 8;
    @(negedge clk);
    OPCODE = 2'b10;
    REQ_ADDR = 23'h060123;
    START = 1;
    @(negedge clk);
    START = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (EXECUTE === 1'b1) seen = 1;
    end
    chk("rst test exec seen", seen, 1);
    repeat (2) @(negedge clk);
    RST = 1;
    @(negedge clk);
    RST = 0;
    chk("mid rst EXECUTE", EXECUTE, 0);
    chk("mid rst READY", READY, 1);
    chk("mid rst OP", OP, 0);
    chk("mid rst RD_DATA", RD_DATA, 0);
    ndone = 0;
    nex = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (DONE) ndone++;
      if (EXECUTE) nex++;
    end
    chk("mid rst no done", ndone, 0);
    chk("mid rst no exec", nex, 0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (model_idle && !BUSY) seen = 1;
    end
    chk("model idle", seen, 1);
    skip_chk = 0;
    pre_dly = 1;

    // long BUSY: 50 cycles per transaction
    xa.delete();
    xd.delete();
    xo.delete();
    stab_bad = 0;
    busy_len = 50;
    do_req(2'b00, 23'h000042, 16'h0000, seen, ndone, gap, rdy);
    nx = xa.size();
    chk("long done seen", seen, 1);
    chk("long done pulses", ndone, 1);
    chk("long done gap", gap, 1);
    chk("long xact count", nx, 2);
    chk("long bus stable", stab_bad, 0);
    chk("long RD_DATA", RD_DATA, 16'hBEEF);
    chk("long ERR", ERR, 0);
    busy_len = 2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
